sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 clk_sig  input  1  single clock; all state SHALL change on its rising edge, except on reset.
REQ-004 rst_sig  input  1  reset; asynchronous, active-low.
REQ-005 w_en_sig  input  1  write request, sampled at rising edge.
REQ-006 r_en_sig  input  1  read request, sampled at rising edge.
REQ-007 data_in  input  WIDTH  write data, captured with w_en_sig.
REQ-008 data_out  output  WIDTH  registered read data.
REQ-009 full  output  1  high when DEPTH entries are stored.
REQ-010 empty  output  1  high when zero entries are stored.

Function
REQ-011 Pointers: write and read pointers of log2(DEPTH)+1 bits each; the MSB is a wrap bit; the lower bits address storage.
REQ-012 Accepted write: w_en_sig=1 and full=0 at a rising edge -> data_in is stored at the write address; write pointer +1.
REQ-013 Accepted read: r_en_sig=1 and empty=0 at a rising edge -> data_out <= entry at the read address; read pointer +1.
REQ-014 Read latency: one clock; data_out is valid from the edge that accepts the read.
REQ-015 data_out holds its last value when no read is accepted.
REQ-016 empty = (write pointer == read pointer), combinational from pointer registers.
REQ-017 full = (address bits equal AND wrap bits differ), combinational from pointer registers.
REQ-018 Write while full: ignored; storage and pointers unchanged; no error flag.
REQ-019 Read while empty: ignored; data_out and pointers unchanged.
REQ-020 Simultaneous read and write, neither full nor empty: both are accepted; occupancy unchanged; flags unchanged.
REQ-021 Simultaneous read and write while empty: only the write is accepted; empty deasserts after the edge.
REQ-022 Simultaneous read and write while full: only the read is accepted; full deasserts after the edge.
REQ-023 Wrap-around: pointers increment modulo 2*DEPTH; ordering stays strict FIFO across any number of wraps.
REQ-024 Data SHALL emerge in exactly the order written; no entry is lost or duplicated.

Reset
REQ-025 rst_sig=0 SHALL immediately clear both pointers, and set data_out=0, empty=1, full=0, regardless of clock.
REQ-026 Storage contents need not be cleared; they are unobservable after reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored data; the first read after release returns the first word written after release.
REQ-028 Release of rst_sig is synchronous to clk_sig; no write or read is accepted on the edge coincident with release.

Structure
REQ-029 Shared package sync_fifo_pkg: default DEPTH/WIDTH constants and the pointer-width (clog2+1) constant function.
REQ-030 One sub-module, sync_fifo_mem: DEPTH x WIDTH storage with a synchronous write port and a registered read port; pointer and flag logic stays in sync_fifo.

Verification
REQ-031 Reset: hold rst_sig=0 for 2 cycles -> empty=1, full=0, data_out=0; release it; idle -> flags unchanged.
REQ-032 Fill: write 0x11..0x18 (8 words) -> full=1 after the 8th edge; a 9th write of 0xFF is ignored; then 8 reads -> 0x11..0x18 in order, empty=1 after the 8th read; a 9th read leaves data_out=0x18.
REQ-033 Concurrent: one cycle after writes begin, assert r_en each cycle for 10 cycles while writing 10 random words -> reads return the same sequence; full never asserts.
REQ-034 Wrap: 3 rounds of 8 writes then 8 reads (24 words, 0x00..0x17) -> exact order preserved; flags correct at each boundary.
REQ-035 Edge cases: r_en+w_en while empty -> only the write is taken (empty=0, data_out unchanged); r_en+w_en while full -> only the read is taken (full=0).
REQ-036 Mid-run reset: write 0xA1, 0xA2; pulse rst_sig low asynchronously between edges -> empty=1 at once; write 0xB1, then read -> 0xB1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Pointer width carries one extra wrap bit above the storage address.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with a synchronous write port and a registered read port.
// The read register resets to zero; the array itself is never cleared.
module sync_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Holds its value whenever no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers and flags here, storage in sync_fifo_mem.
// full/empty are decoded combinationally from the pointer registers.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_sig,
  input  logic             rst_sig,
  input  logic             w_en_sig,
  input  logic             r_en_sig,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_accept_c;
  logic          rd_accept_c;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Full blocks writes and empty blocks reads, which also resolves the simultaneous cases.
  assign wr_accept_c = w_en_sig && !full;
  assign rd_accept_c = r_en_sig && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_accept_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk_sig),
    .rst_n   (rst_sig),
    .we_i    (wr_accept_c),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_accept_c),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 8;

  logic             clk_sig;
  logic             rst_sig;
  logic             w_en_sig;
  logic             r_en_sig;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  int n_checks;
  int n_errors;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_dout;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk_sig  (clk_sig),
    .rst_sig  (rst_sig),
    .w_en_sig (w_en_sig),
    .r_en_sig (r_en_sig),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dout"},  32'(data_out), 32'(model_dout));
    check({tag, ".full"},  32'(full),     32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty),    32'(model_q.size() == 0));
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1ns later.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit full_m, empty_m;
    w_en_sig = w;
    r_en_sig = r;
    data_in  = d;
    @(posedge clk_sig);
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    if (r && !empty_m) model_dout = model_q.pop_front();
    if (w && !full_m)  model_q.push_back(d);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] wd;
    n_checks   = 0;
    n_errors   = 0;
    model_dout = '0;
    w_en_sig   = 1'b0;
    r_en_sig   = 1'b0;
    data_in    = '0;
    rst_sig    = 1'b0;

    // Reset held for two cycles, then released between edges.
    repeat (2) @(posedge clk_sig);
    #1;
    check_outputs("reset");
    @(negedge clk_sig);
    rst_sig = 1'b1;
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b0, '0);

    // Fill, overflow attempt, drain, underflow attempt.
    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, WIDTH'(8'h11 + i));
    check("fill.full8", 32'(full), 32'd1);
    cycle("overflow", 1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      cycle("drain", 1'b0, 1'b1, '0);
      check("drain.order", 32'(data_out), 32'(8'h11 + i));
    end
    check("drain.empty8", 32'(empty), 32'd1);
    cycle("underflow", 1'b0, 1'b1, '0);
    check("underflow.hold", 32'(data_out), 32'h18);

    // Concurrent write/read streaming.
    for (int i = 0; i < 11; i++) begin
      wd = WIDTH'($urandom);
      cycle("concurrent", i < 10, i > 0, wd);
      check("concurrent.nofull", 32'(full), 32'd0);
    end

    // Three wrap rounds.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 8; i++) cycle("wrap.wr", 1'b1, 1'b0, WIDTH'(rnd * 8 + i));
      for (int i = 0; i < 8; i++) begin
        cycle("wrap.rd", 1'b0, 1'b1, '0);
        check("wrap.order", 32'(data_out), 32'(rnd * 8 + i));
      end
    end

    // Simultaneous read/write at empty and at full.
    cycle("edge.empty_rw", 1'b1, 1'b1, 8'h5A);
    check("edge.empty_rw.dout", 32'(data_out), 32'h17);
    check("edge.empty_rw.empty", 32'(empty), 32'd0);
    for (int i = 0; i < 7; i++) cycle("edge.fill", 1'b1, 1'b0, WIDTH'(8'h60 + i));
    cycle("edge.full_rw", 1'b1, 1'b1, 8'hEE);
    check("edge.full_rw.full", 32'(full), 32'd0);
    check("edge.full_rw.dout", 32'(data_out), 32'h5A);
    while (model_q.size() != 0) cycle("edge.drain", 1'b0, 1'b1, '0);

    // Asynchronous mid-run reset pulse between edges.
    cycle("mid.wr", 1'b1, 1'b0, 8'hA1);
    cycle("mid.wr", 1'b1, 1'b0, 8'hA2);
    w_en_sig = 1'b0;
    #3;
    rst_sig = 1'b0;
    model_q.delete();
    model_dout = '0;
    #1;
    check_outputs("mid.async");
    #1;
    rst_sig = 1'b1;
    cycle("mid.wrB1", 1'b1, 1'b0, 8'hB1);
    cycle("mid.rd", 1'b0, 1'b1, '0);
    check("mid.rdB1", 32'(data_out), 32'hB1);

    // Random traffic with shifting write/read bias to reach both flags.
    for (int seg = 0; seg < 6; seg++) begin
      int wp;
      int rp;
      wp = (seg % 3 == 0) ? 80 : ((seg % 3 == 1) ? 20 : 50);
      rp = 100 - wp;
      for (int i = 0; i < 60; i++) begin
        cycle("random", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, WIDTH'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
